// File: rtl/stopwatch_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_core_pkg
//  Description : Shared constants and helpers for the stopwatch core: digit
//                width, prescaler ratio computation with its validity check,
//                and per-digit base extraction from the packed base vector.
//  Revision    : 1.0  initial release
// ============================================================================
package stopwatch_core_pkg;

    // Every digit is carried as a 4-bit BCD-style nibble regardless of base.
    localparam int DIGIT_W = 4;

    // Largest supported digit count; the packed base vector is at most 32 bits.
    localparam int MAX_DIGITS = 8;

    // Exact clock-to-tick ratio.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        if (tick_hz <= 0) begin
            return 0;
        end
        return clk_hz / tick_hz;
    endfunction

    // True when the ratio is exact and the prescaler has at least two states.
    function automatic bit div_ok(input int clk_hz, input int tick_hz);
        if (tick_hz <= 0) begin
            return 1'b0;
        end
        return ((clk_hz % tick_hz) == 0) && ((clk_hz / tick_hz) >= 2);
    endfunction

    // Base of digit k from a packed base vector (digit 0 in the low nibble).
    function automatic int digit_base(input logic [DIGIT_W*MAX_DIGITS-1:0] bases,
                                      input int k);
        return int'(bases[k*DIGIT_W +: DIGIT_W]);
    endfunction

endpackage : stopwatch_core_pkg
`default_nettype wire

// File: rtl/stopwatch_digit.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_digit
//  Description : Single counter digit with a configurable base. Steps up or
//                down by one when enabled, wraps at its own boundaries and
//                clamps loaded values to base-1. Carry decisions belong to the
//                parent; this block only reports at_max / at_zero.
//  Revision    : 1.0  initial release
// ============================================================================
module stopwatch_digit
    import stopwatch_core_pkg::*;
#(
    parameter int BASE = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_value,
    input  logic               enable,
    input  logic               up_down,
    output logic [DIGIT_W-1:0] value,
    output logic               at_max,
    output logic               at_zero
);

    if ((BASE < 2) || (BASE > 10)) begin : g_bad_base
        $error("stopwatch_digit: BASE must be in 2..10");
    end

    localparam logic [DIGIT_W-1:0] MAX_VAL = DIGIT_W'(BASE - 1);

    logic [DIGIT_W-1:0] load_clamped;

    // Out-of-range load digits saturate at the largest legal value.
    assign load_clamped = (load_value > MAX_VAL) ? MAX_VAL : load_value;

    assign at_max  = (value == MAX_VAL);
    assign at_zero = (value == '0);

    // Digit register: clear beats load beats a counting step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (load) begin
            value <= load_clamped;
        end else if (enable) begin
            if (up_down) begin
                value <= at_max ? '0 : value + 1'b1;
            end else begin
                value <= at_zero ? MAX_VAL : value - 1'b1;
            end
        end
    end

endmodule : stopwatch_digit
`default_nettype wire

// File: rtl/stopwatch_core.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_core
//  Description : Multi-digit stopwatch / countdown. An exact-ratio prescaler
//                produces count ticks while running; each tick steps a cascade
//                of per-digit counters. Supports start/stop, clear, parallel
//                load, lap hold and wrap-or-hold at the count limit.
//  Revision    : 1.0  initial release
// ============================================================================
module stopwatch_core
    import stopwatch_core_pkg::*;
#(
    parameter int                          NUM_DIGITS    = 4,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] DIGIT_BASES = {4'd6, 4'd10, 4'd6, 4'd10},
    parameter int                          CLK_FREQ_HZ   = 100_000_000,
    parameter int                          TICK_HZ       = 1,
    parameter int                          STOP_AT_LIMIT = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          clear,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_value,
    input  logic                          up_down,
    input  logic                          lap,
    output logic [DIGIT_W*NUM_DIGITS-1:0] count,
    output logic [DIGIT_W*NUM_DIGITS-1:0] display,
    output logic                          running,
    output logic                          lap_active,
    output logic                          wrap,
    output logic                          done
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (!div_ok(CLK_FREQ_HZ, TICK_HZ)) begin : g_bad_div
        $error("stopwatch_core: CLK_FREQ_HZ must be an exact multiple (>=2) of TICK_HZ");
    end

    if ((NUM_DIGITS < 1) || (NUM_DIGITS > MAX_DIGITS)) begin : g_bad_digits
        $error("stopwatch_core: NUM_DIGITS must be in 1..8");
    end

    localparam int            DIV       = calc_div(CLK_FREQ_HZ, TICK_HZ);
    localparam int            PW        = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
    localparam bit            HOLD_MODE = (STOP_AT_LIMIT != 0);
    localparam int            CW        = DIGIT_W * NUM_DIGITS;

    // ------------------------------------------------------------------------
    // Internal state
    // ------------------------------------------------------------------------
    logic [PW-1:0]         prescaler;
    logic [CW-1:0]         lap_reg;
    logic [NUM_DIGITS-1:0] at_max;
    logic [NUM_DIGITS-1:0] at_zero;
    logic [NUM_DIGITS-1:0] digit_en;
    logic [NUM_DIGITS:0]   carry;

    logic pre_at_end;
    logic tick;
    logic at_limit;
    logic step_allowed;

    // A tick is only honoured when no higher-priority control is present:
    // clear/load discard it and stop suppresses it.
    assign pre_at_end = (prescaler == PRE_LAST);
    assign tick       = running && pre_at_end && !clear && !load && !stop;

    // The limit depends on direction: all-max going up, all-zero going down.
    assign at_limit = up_down ? (&at_max) : (&at_zero);

    // In hold mode a tick at the limit must leave every digit untouched.
    assign step_allowed = tick && !(HOLD_MODE && at_limit);

    // ------------------------------------------------------------------------
    // Carry chain: digit k steps when all lower digits are at their boundary
    // for the current direction. At the limit every digit steps, which is
    // exactly the all-0 / all-max roll-over.
    // ------------------------------------------------------------------------
    assign carry[0] = step_allowed;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        assign carry[k+1]  = carry[k] && (up_down ? at_max[k] : at_zero[k]);
        assign digit_en[k] = carry[k];

        stopwatch_digit #(
            .BASE (digit_base(32'(DIGIT_BASES), k))
        ) u_digit (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (clear),
            .load       (load),
            .load_value (load_value[k*DIGIT_W +: DIGIT_W]),
            .enable     (digit_en[k]),
            .up_down    (up_down),
            .value      (count[k*DIGIT_W +: DIGIT_W]),
            .at_max     (at_max[k]),
            .at_zero    (at_zero[k])
        );
    end

    // Run control and prescaler, in priority clear > load > stop > start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running   <= 1'b0;
            prescaler <= '0;
        end else if (clear || load) begin
            prescaler <= '0;
        end else if (stop) begin
            running   <= 1'b0;
        end else if (start && !running) begin
            running   <= 1'b1;
            prescaler <= '0;
        end else if (running) begin
            if (pre_at_end) begin
                prescaler <= '0;
                if (HOLD_MODE && at_limit) begin
                    running <= 1'b0;
                end
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    // Limit event pulses, high for the single cycle after the tick edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap <= 1'b0;
            done <= 1'b0;
        end else begin
            wrap <= tick && at_limit && !HOLD_MODE;
            done <= tick && at_limit && HOLD_MODE;
        end
    end

    // Lap hold: first pulse freezes the current count, second releases it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_reg    <= '0;
            lap_active <= 1'b0;
        end else if (clear) begin
            lap_reg    <= '0;
            lap_active <= 1'b0;
        end else if (lap) begin
            if (lap_active) begin
                lap_active <= 1'b0;
            end else begin
                lap_reg    <= count;
                lap_active <= 1'b1;
            end
        end
    end

    assign display = lap_active ? lap_reg : count;

endmodule : stopwatch_core
`default_nettype wire
